// File: rtl/ddr_sched_pkg.sv
// Shared definitions for the MCB port-0 scheduler: state encoding, MCB
// command opcodes, bus widths and the burst address alignment helper.
package ddr_sched_pkg;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;

  // Scheduler state register encoding (3 bits).
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_READY    = 3'd1;
  localparam state_t ST_WR_FILL  = 3'd2;
  localparam state_t ST_WR_CMD   = 3'd3;
  localparam state_t ST_RD_CMD   = 3'd4;
  localparam state_t ST_RD_DRAIN = 3'd5;

  // MCB p0_cmd_instr opcodes.
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // Bit positions in the arbiter request/grant vectors.
  localparam int unsigned GNT_WR = 0;
  localparam int unsigned GNT_RD = 1;

  // Bursts always start on a 32-bit word boundary.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
    return a & {{(ADDR_W-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/ddr_rr_arbiter2.sv
// Two-input round-robin arbiter.
//   clk, reset : clock, synchronous active-low reset
//   req[1:0]   : bit 0 = writer, bit 1 = fetcher
//   update     : commit the current grant into the last-grant register
//   grant[1:0] : one-hot grant (all zero when nothing is requested)
// On a tie the side that was not granted last wins; after reset the last
// grant is the writer, so the fetcher wins the first tie.
module ddr_rr_arbiter2
  import ddr_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_rd;

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_rd ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_rd <= 1'b0;
    end else if (update && (|grant)) begin
      last_rd <= grant[GNT_RD];
    end
  end

endmodule

// File: rtl/ddr_port_scheduler.sv
// Shares MCB user port 0 between the pixel writer and the display line
// fetcher, one fixed-length burst at a time, round-robin on ties.
//   clk, reset        : clock, synchronous active-low reset
//   mem_calib_done    : asynchronous MIG calibration flag (2-flop synchronised)
//   wr_req/wr_addr    : writer burst request and byte address
//   wr_data/wr_pop    : FWFT write data and its consume strobe
//   wr_done           : pulse when the write command is issued
//   rd_req/rd_addr    : fetcher burst request and byte address
//   rd_data/rd_valid  : returned read words
//   rd_done           : pulse with the last word of a read burst
//   busy              : scheduler not in READY
//   p0_*              : MCB port-0 command, write and read FIFO interface
module ddr_port_scheduler
  import ddr_sched_pkg::*;
#(
  parameter int unsigned BURST_LEN = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_calib_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,
  output logic              wr_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_done,
  output logic              busy,
  input  logic              p0_cmd_full,
  input  logic              p0_wr_full,
  input  logic              p0_rd_empty,
  input  logic [DATA_W-1:0] p0_rd_data,
  output logic              p0_cmd_en,
  output logic              p0_wr_en,
  output logic              p0_rd_en,
  output logic [2:0]        p0_cmd_instr,
  output logic [5:0]        p0_cmd_bl,
  output logic [ADDR_W-1:0] p0_cmd_byte_addr,
  output logic [DATA_W-1:0] p0_wr_data
);

  localparam logic [6:0] LEN  = 7'(BURST_LEN);
  localparam logic [6:0] LAST = 7'(BURST_LEN - 1);

  logic              calib_meta;
  logic              calib_sync;
  state_t            state;
  logic [6:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        grant;

  ddr_rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({rd_req, wr_req}),
    .update (state == ST_READY),
    .grant  (grant)
  );

  assign p0_cmd_bl        = 6'(BURST_LEN - 1);
  assign p0_cmd_byte_addr = addr_q;
  assign p0_wr_data       = wr_data;
  assign rd_data          = p0_rd_data;
  assign busy             = (state != ST_READY);

  always_comb begin
    wr_pop       = 1'b0;
    p0_wr_en     = 1'b0;
    p0_cmd_en    = 1'b0;
    p0_cmd_instr = CMD_WRITE;
    wr_done      = 1'b0;
    p0_rd_en     = 1'b0;
    rd_valid     = 1'b0;
    rd_done      = 1'b0;
    case (state)
      ST_WR_FILL: begin
        wr_pop   = !p0_wr_full && (cnt < LEN);
        p0_wr_en = wr_pop;
      end
      ST_WR_CMD: begin
        p0_cmd_en = !p0_cmd_full;
        wr_done   = p0_cmd_en;
      end
      ST_RD_CMD: begin
        p0_cmd_en    = !p0_cmd_full;
        p0_cmd_instr = CMD_READ;
      end
      ST_RD_DRAIN: begin
        p0_rd_en = !p0_rd_empty;
        rd_valid = p0_rd_en;
        rd_done  = rd_valid && (cnt == LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      calib_meta <= 1'b0;
      calib_sync <= 1'b0;
      state      <= ST_IDLE;
      cnt        <= '0;
      addr_q     <= '0;
    end else begin
      calib_meta <= mem_calib_done;
      calib_sync <= calib_meta;
      case (state)
        ST_IDLE: begin
          if (calib_sync) state <= ST_READY;
        end
        ST_READY: begin
          if (grant[GNT_WR]) begin
            addr_q <= align_word(wr_addr);
            state  <= ST_WR_FILL;
          end else if (grant[GNT_RD]) begin
            addr_q <= align_word(rd_addr);
            state  <= ST_RD_CMD;
          end
        end
        ST_WR_FILL: begin
          if (wr_pop) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= ST_WR_CMD;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
        end
        ST_WR_CMD: begin
          if (p0_cmd_en) state <= ST_READY;
        end
        ST_RD_CMD: begin
          if (p0_cmd_en) state <= ST_RD_DRAIN;
        end
        ST_RD_DRAIN: begin
          if (rd_valid) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= ST_READY;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_port_scheduler.sv
// Self-checking bench for ddr_port_scheduler: directed timing scenarios plus
// randomized request/backpressure rounds, scoreboarded against a grant-order
// model and queues of expected commands and data words.
module tb_ddr_port_scheduler;
  import ddr_sched_pkg::*;

  localparam int unsigned BL = 16;

  logic        clk = 1'b0;
  logic        reset, mem_calib_done;
  logic        wr_req, rd_req;
  logic [29:0] wr_addr, rd_addr;
  logic [31:0] wr_data = '0;
  logic        wr_pop, wr_done, rd_valid, rd_done, busy;
  logic [31:0] rd_data;
  logic        p0_cmd_full, p0_wr_full;
  logic        p0_rd_empty = 1'b1;
  logic [31:0] p0_rd_data = '0;
  logic        p0_cmd_en, p0_wr_en, p0_rd_en;
  logic [2:0]  p0_cmd_instr;
  logic [5:0]  p0_cmd_bl;
  logic [29:0] p0_cmd_byte_addr;
  logic [31:0] p0_wr_data;

  always #5 clk = ~clk;

  ddr_port_scheduler #(.BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset), .mem_calib_done(mem_calib_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_pop(wr_pop),
    .wr_done(wr_done), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_done(rd_done), .busy(busy),
    .p0_cmd_full(p0_cmd_full), .p0_wr_full(p0_wr_full), .p0_rd_empty(p0_rd_empty),
    .p0_rd_data(p0_rd_data), .p0_cmd_en(p0_cmd_en), .p0_wr_en(p0_wr_en),
    .p0_rd_en(p0_rd_en), .p0_cmd_instr(p0_cmd_instr), .p0_cmd_bl(p0_cmd_bl),
    .p0_cmd_byte_addr(p0_cmd_byte_addr), .p0_wr_data(p0_wr_data)
  );

  typedef struct {
    logic        is_rd;
    logic [29:0] addr;
  } cmd_t;

  cmd_t        exp_cmd[$];
  logic [31:0] exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] wr_src[$];
  logic [31:0] rd_fifo[$];

  int n_checks = 0;
  int n_fail   = 0;
  int rd_mode  = 0;     // 0: data ready at once, 1: empty every other cycle, 2: random
  bit bp_rand  = 1'b0;  // random wr_full / cmd_full backpressure
  bit model_last_rd = 1'b0;
  int wr_pops_total = 0;
  int rd_words_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not occur as required (t=%0t)", name, $time);
  endtask

  // ---------------- MCB / requester environment ----------------
  bit cap_wr_pop, cap_rd_pop, cap_rd_cmd;
  bit rd_stall = 1'b0;

  always @(negedge clk) begin
    cap_wr_pop = reset && wr_pop;
    cap_rd_pop = reset && p0_rd_en;
    cap_rd_cmd = reset && p0_cmd_en && (p0_cmd_instr == CMD_READ);
  end

  always begin
    @(posedge clk);
    #1;
    if (cap_wr_pop && wr_src.size() > 0) void'(wr_src.pop_front());
    if (cap_rd_pop && rd_fifo.size() > 0) void'(rd_fifo.pop_front());
    if (cap_rd_cmd) begin
      for (int i = 0; i < int'(BL); i++) begin
        logic [31:0] w;
        w = $urandom;
        rd_fifo.push_back(w);
        exp_rd.push_back(w);
      end
    end
    case (rd_mode)
      1:       rd_stall = ~rd_stall;
      2:       rd_stall = ($urandom_range(0, 2) == 0);
      default: rd_stall = 1'b0;
    endcase
    if (bp_rand) begin
      p0_wr_full  = ($urandom_range(0, 3) == 0);
      p0_cmd_full = ($urandom_range(0, 3) == 0);
    end
    wr_data     = (wr_src.size() > 0) ? wr_src[0] : 32'h0;
    p0_rd_data  = (rd_fifo.size() > 0) ? rd_fifo[0] : 32'hDEAD_BEEF;
    p0_rd_empty = (rd_fifo.size() == 0) || rd_stall;
  end

  // ---------------- Monitor / scoreboard ----------------
  int mon_pops = 0;
  int mon_rwords = 0;

  always @(negedge clk) begin
    if (!reset) begin
      mon_pops   = 0;
      mon_rwords = 0;
    end else begin
      if (wr_pop || p0_wr_en) begin
        check("wr_pop_vs_wr_en", 32'(wr_pop), 32'(p0_wr_en));
        if (exp_wr.size() == 0) flag("unexpected_wr_pop");
        else check("wr_data", p0_wr_data, exp_wr.pop_front());
        mon_pops++;
        wr_pops_total++;
      end
      if (p0_cmd_en) begin
        if (exp_cmd.size() == 0) begin
          flag("unexpected_cmd");
        end else begin
          cmd_t e;
          e = exp_cmd.pop_front();
          check("cmd_instr", 32'(p0_cmd_instr), e.is_rd ? 32'(CMD_READ) : 32'(CMD_WRITE));
          check("cmd_addr", 32'(p0_cmd_byte_addr), 32'(e.addr));
          check("cmd_bl", 32'(p0_cmd_bl), BL - 1);
          if (!e.is_rd) begin
            check("pops_per_burst", 32'(mon_pops), BL);
            check("wr_done_with_cmd", 32'(wr_done), 1);
            mon_pops = 0;
          end else begin
            check("no_wr_done_on_read", 32'(wr_done), 0);
          end
        end
      end else if (wr_done) begin
        flag("wr_done_without_cmd");
      end
      if (rd_valid || p0_rd_en) begin
        check("rd_valid_vs_rd_en", 32'(rd_valid), 32'(p0_rd_en));
        if (exp_rd.size() == 0) flag("unexpected_rd_word");
        else check("rd_data", rd_data, exp_rd.pop_front());
        mon_rwords++;
        rd_words_total++;
        check("rd_done_position", 32'(rd_done), 32'(mon_rwords == int'(BL)));
        if (mon_rwords == int'(BL)) mon_rwords = 0;
      end else if (rd_done) begin
        flag("rd_done_without_word");
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic flush();
    exp_cmd.delete();
    exp_wr.delete();
    exp_rd.delete();
    wr_src.delete();
    rd_fifo.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_wr_pop"}, 32'(wr_pop), 0);
    check({tag, "_p0_wr_en"}, 32'(p0_wr_en), 0);
    check({tag, "_p0_cmd_en"}, 32'(p0_cmd_en), 0);
    check({tag, "_p0_rd_en"}, 32'(p0_rd_en), 0);
    check({tag, "_wr_done"}, 32'(wr_done), 0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 0);
    check({tag, "_rd_done"}, 32'(rd_done), 0);
    check({tag, "_cmd_addr"}, 32'(p0_cmd_byte_addr), 0);
    check({tag, "_cmd_instr"}, 32'(p0_cmd_instr), 0);
    check({tag, "_cmd_bl"}, 32'(p0_cmd_bl), BL - 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    @(posedge clk); #1;
    check_idle("reset");
    flush();
    model_last_rd = 1'b0;
    reset = 1'b1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 50);
    if (busy) flag("wait_ready_timeout");
  endtask

  // Grant-order model: while both sides still want bursts the side not served
  // last goes next; otherwise the remaining side runs alone.
  task automatic plan(input int n_wr, input int n_rd, input logic [29:0] wa, input logic [29:0] ra);
    int w, r;
    bit take_rd;
    w = n_wr;
    r = n_rd;
    while (w > 0 || r > 0) begin
      take_rd = (w > 0 && r > 0) ? !model_last_rd : (r > 0);
      model_last_rd = take_rd;
      if (take_rd) begin
        exp_cmd.push_back('{1'b1, ra & 30'h3FFF_FFFC});
        r--;
      end else begin
        exp_cmd.push_back('{1'b0, wa & 30'h3FFF_FFFC});
        for (int i = 0; i < int'(BL); i++) begin
          logic [31:0] d;
          d = $urandom;
          wr_src.push_back(d);
          exp_wr.push_back(d);
        end
        w--;
      end
    end
  endtask

  // Hold each request until it has seen its burst count of done pulses.
  task automatic serve(input int n_wr, input int n_rd, input logic [29:0] wa,
                       input logic [29:0] ra, output int busy_low);
    int wl, rl, cyc;
    wl = n_wr; rl = n_rd; cyc = 0; busy_low = 0;
    @(posedge clk); #1;
    wr_addr = wa; rd_addr = ra;
    wr_req = (wl > 0); rd_req = (rl > 0);
    while ((wl > 0 || rl > 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (!busy) busy_low++;
      if (wr_done) wl--;
      if (rd_done) rl--;
      @(posedge clk); #1;
      if (wl <= 0) wr_req = 1'b0;
      if (rl <= 0) rd_req = 1'b0;
    end
    if (wl > 0 || rl > 0) begin
      flag("serve_timeout");
      do_reset();
      wait_ready();
    end
  endtask

  // Single write with cycle indices relative to the READY cycle (index 0)
  // in which the request is first seen.
  task automatic write_timed(input logic [29:0] wa, input bit bp,
                             output int first_pop, output int cmd_cyc, output int pops);
    int cyc;
    plan(1, 0, wa, 30'h0);
    @(posedge clk); #1;
    wr_addr = wa; wr_req = 1'b1;
    cyc = -1; first_pop = -1; cmd_cyc = -1; pops = 0;
    while (cmd_cyc < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (wr_pop) begin
        pops++;
        if (first_pop < 0) first_pop = cyc;
      end
      if (p0_cmd_en) cmd_cyc = cyc;
      @(posedge clk); #1;
      if (bp) begin
        p0_wr_full  = (cyc + 1 >= 5) && (cyc + 1 <= 8);
        p0_cmd_full = (cyc + 1 >= 21) && (cyc + 1 <= 23);
      end
    end
    wr_req = 1'b0; p0_wr_full = 1'b0; p0_cmd_full = 1'b0;
    if (cmd_cyc < 0) flag("write_timed_timeout");
  endtask

  // ---------------- Test sequence ----------------
  initial begin
    int fp, cc, np, bl_cnt, hits, lat, base, n;
    logic [29:0] wa, ra;

    reset = 1'b0; mem_calib_done = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0; wr_addr = '0; rd_addr = '0;
    p0_cmd_full = 1'b0; p0_wr_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("por");
    reset = 1'b1;

    // Calibration gate: nothing moves while calib is low.
    plan(1, 0, 30'h0000_0040, 30'h0);
    @(posedge clk); #1;
    wr_addr = 30'h0000_0040; wr_req = 1'b1;
    hits = 0;
    repeat (100) begin
      @(negedge clk);
      if (wr_pop || p0_cmd_en) hits++;
    end
    check("calib_gate_activity", 32'(hits), 0);
    @(posedge clk); #1;
    mem_calib_done = 1'b1;
    // Raise cycle is 0: two sync edges, IDLE->READY, READY->WR_FILL.
    lat = -1;
    do begin
      @(negedge clk);
      lat++;
    end while (!wr_pop && lat < 20);
    check("calib_first_pop_cycle", 32'(lat), 4);
    n = 0;
    while (!wr_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!wr_done) flag("calib_burst_done");
    @(posedge clk); #1;
    wr_req = 1'b0;
    wait_ready();

    // Single unaligned write, no backpressure.
    write_timed(30'h0000_0103, 1'b0, fp, cc, np);
    check("single_first_pop", 32'(fp), 1);
    check("single_cmd_cycle", 32'(cc), 17);
    check("single_pop_count", 32'(np), BL);
    @(negedge clk);
    check("single_busy_after", 32'(busy), 0);

    // Write with 4 cycles of wr_full then 3 cycles of cmd_full.
    write_timed(30'h0012_3458, 1'b1, fp, cc, np);
    check("bp_first_pop", 32'(fp), 1);
    check("bp_cmd_delay", 32'(cc - fp), BL + 4 + 3);
    check("bp_pop_count", 32'(np), BL);
    @(negedge clk);

    // Read with rd_empty toggling every other cycle.
    rd_mode = 1;
    base = rd_words_total;
    plan(0, 1, 30'h0, 30'h0000_0400);
    serve(0, 1, 30'h0, 30'h0000_0400, bl_cnt);
    check("read_word_count", 32'(rd_words_total - base), BL);
    rd_mode = 0;

    // Tie: both held, read wins first after reset, READY used as grant cycle.
    do_reset();
    wait_ready();
    plan(2, 2, 30'h0000_2000, 30'h0000_3004);
    serve(2, 2, 30'h0000_2000, 30'h0000_3004, bl_cnt);
    check("tie_ready_cycles", 32'(bl_cnt), 4);

    // Reset in the middle of a write fill.
    plan(1, 0, 30'h0000_5000, 30'h0);
    @(posedge clk); #1;
    wr_addr = 30'h0000_5000; wr_req = 1'b1;
    np = 0; n = 0;
    while (np < 6 && n < 100) begin
      @(negedge clk);
      n++;
      if (wr_pop) np++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("pop7_in_reset_cycle", 32'(wr_pop), 1);
    @(posedge clk); #1;
    reset = 1'b1; wr_req = 1'b0;
    flush();
    model_last_rd = 1'b0;
    @(negedge clk);
    check_idle("midreset");
    check("midreset_busy_idle", 32'(busy), 1);
    base = wr_pops_total;
    wait_ready();
    plan(1, 0, 30'h0000_6000, 30'h0);
    serve(1, 0, 30'h0000_6000, 30'h0, bl_cnt);
    check("fresh_burst_pops", 32'(wr_pops_total - base), BL);

    // Randomized rounds with backpressure on every FIFO.
    bp_rand = 1'b1;
    rd_mode = 2;
    for (int r = 0; r < 25; r++) begin
      int nw, nr;
      nw = $urandom_range(0, 2);
      nr = $urandom_range(0, 2);
      if (nw == 0 && nr == 0) nw = 1;
      wa = 30'($urandom);
      ra = 30'($urandom);
      plan(nw, nr, wa, ra);
      serve(nw, nr, wa, ra, bl_cnt);
    end
    bp_rand = 1'b0;
    rd_mode = 0;
    @(posedge clk); #1;
    p0_wr_full = 1'b0; p0_cmd_full = 1'b0;
    repeat (4) @(negedge clk);

    check("leftover_cmds", 32'(exp_cmd.size()), 0);
    check("leftover_wr_words", 32'(exp_wr.size()), 0);
    check("leftover_rd_words", 32'(exp_rd.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
